// File: rtl/flash_period_meter_pkg.sv
// -----------------------------------------------------------------------------
// flash_period_meter_pkg
// Shared timing constants and state encoding for the flash period meter and
// other slow-input receivers.
//   DEFAULT_OSC_CLOCK : board oscillator frequency in Hz
//   state_t           : measurement FSM states
// -----------------------------------------------------------------------------
package flash_period_meter_pkg;

    localparam int DEFAULT_OSC_CLOCK = 27000000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALLED = 2'd2
    } state_t;

endpackage

// File: rtl/flash_period_meter_if.sv
// -----------------------------------------------------------------------------
// flash_period_meter_if
// Groups the measured input and the measurement results of the flash period
// meter.
//   flash_in    : slow square wave under measurement
//   half_period : last accepted interval between edges, in clock cycles
//   level       : input level during the interval held in half_period
//   valid       : one-cycle strobe, half_period/level updated
//   glitch      : one-cycle strobe, a too-short interval was discarded
//   stalled     : no edge seen for the timeout period
// Modports:
//   master : the meter (consumes flash_in, drives the results)
//   slave  : the user (drives flash_in, reads the results)
// -----------------------------------------------------------------------------
interface flash_period_meter_if #(
    parameter int CNT_W = 25
);

    logic             flash_in;
    logic [CNT_W-1:0] half_period;
    logic             level;
    logic             valid;
    logic             glitch;
    logic             stalled;

    modport master (
        input  flash_in,
        output half_period,
        output level,
        output valid,
        output glitch,
        output stalled
    );

    modport slave (
        output flash_in,
        input  half_period,
        input  level,
        input  valid,
        input  glitch,
        input  stalled
    );

endinterface

// File: rtl/flash_period_meter_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous slow input into the clock domain through a 2-flop
// synchronizer, keeps one history flop and flags every transition.
//   clk        : sampling clock
//   rst_n      : asynchronous active-low reset
//   din        : asynchronous input
//   edge_pulse : high for one cycle when the synchronized input changed
//   level      : synchronized level before the change (history flop)
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_pulse,
    output logic level
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability, s3 remembers the previous synchronized value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_pulse = s2 ^ s3;
    assign level      = s3;

endmodule

// File: rtl/flash_period_meter.sv
// -----------------------------------------------------------------------------
// flash_period_meter
// Measures every half-period of a slow external square wave in in_clk cycles.
// Intervals shorter than MIN_CYCLES are reported as glitches; no edge for
// TIMEOUT_CYCLES raises stalled until the next edge.
//   in_clk  : system clock
//   reset_n : asynchronous active-low reset
//   bus     : flash_period_meter_if master modport (flash_in in, results out)
// -----------------------------------------------------------------------------
module flash_period_meter
    import flash_period_meter_pkg::*;
#(
    parameter int OSC_CLOCK      = DEFAULT_OSC_CLOCK,
    parameter int CNT_W          = 25,
    parameter int TIMEOUT_CYCLES = OSC_CLOCK,
    parameter int MIN_CYCLES     = 16
) (
    input logic                  in_clk,
    input logic                  reset_n,
    flash_period_meter_if.master bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] MIN_VAL     = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0] ONE_VAL     = CNT_W'(1);

    logic             edge_pulse;
    logic             sync_level;
    logic [CNT_W-1:0] counter;
    state_t           state;
    logic [CNT_W-1:0] half_period_q;
    logic             level_q;
    logic             valid_q;
    logic             glitch_q;
    logic             stalled_q;

    sync_edge_det u_sync (
        .clk        (in_clk),
        .rst_n      (reset_n),
        .din        (bus.flash_in),
        .edge_pulse (edge_pulse),
        .level      (sync_level)
    );

    // Restarting at 1 on an edge means the value seen at the next edge cycle
    // is exactly the number of cycles between the two edge cycles.
    // Saturation keeps a dead input from wrapping into a bogus short interval.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            counter <= '0;
        end else if (edge_pulse) begin
            counter <= ONE_VAL;
        end else if (counter < TIMEOUT_VAL) begin
            counter <= counter + ONE_VAL;
        end
    end

    // The first edge after reset and the first edge after a stall only arm
    // the measurement: the interval leading up to them is unknown.
    // An edge arriving while the counter sits at the timeout still counts as
    // a valid interval, so the edge check comes before the stall check.
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            half_period_q <= '0;
            level_q       <= 1'b0;
            valid_q       <= 1'b0;
            glitch_q      <= 1'b0;
            stalled_q     <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            glitch_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (edge_pulse) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (edge_pulse) begin
                        if (counter >= MIN_VAL) begin
                            half_period_q <= counter;
                            level_q       <= sync_level;
                            valid_q       <= 1'b1;
                        end else begin
                            glitch_q <= 1'b1;
                        end
                    end else if (counter == TIMEOUT_VAL) begin
                        state     <= STALLED;
                        stalled_q <= 1'b1;
                    end
                end
                STALLED: begin
                    if (edge_pulse) begin
                        state     <= MEASURE;
                        stalled_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    stalled_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.half_period = half_period_q;
    assign bus.level       = level_q;
    assign bus.valid       = valid_q;
    assign bus.glitch      = glitch_q;
    assign bus.stalled     = stalled_q;

endmodule

// File: tb/tb_flash_period_meter.sv
// -----------------------------------------------------------------------------
// tb_flash_period_meter
// Directed testbench for flash_period_meter with CNT_W=8, TIMEOUT_CYCLES=100,
// MIN_CYCLES=4. Inputs change on the falling clock edge; an input toggle made
// at falling edge N is reported on the outputs seen at falling edge N+3.
// -----------------------------------------------------------------------------
module tb_flash_period_meter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 100;
    localparam int MIN     = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    logic prev_level;

    always #5 clk = ~clk;

    flash_period_meter_if #(.CNT_W(CNT_W)) bus ();

    flash_period_meter #(
        .OSC_CLOCK      (27000000),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MIN_CYCLES     (MIN)
    ) dut (
        .in_clk  (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Waits n falling clock edges
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Flips the measured input, remembering the level it had before
    task automatic flip();
        prev_level  = bus.flash_in;
        bus.flash_in = ~bus.flash_in;
    endtask

    // Reset with the input low, all outputs must be cleared
    task automatic test_reset();
        bus.flash_in = 1'b0;
        reset_n      = 1'b0;
        wait_neg(3);
        reset_n = 1'b1;
        wait_neg(1);
        checks++;
        if ({bus.half_period, bus.level, bus.valid, bus.glitch, bus.stalled} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: hp=%0d lvl=%0b v=%0b g=%0b s=%0b expected all 0",
                     bus.half_period, bus.level, bus.valid, bus.glitch, bus.stalled);
        end
        wait_neg(4);
    endtask

    // Symmetric 20-cycle wave; first edge only arms the meter
    task automatic test_square();
        flip();
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_edge_valid: got %0b expected 0", bus.valid);
        end
        wait_neg(17);
        for (int i = 0; i < 4; i++) begin
            flip();
            wait_neg(3);
            checks++;
            if (bus.valid !== 1'b1 || bus.half_period !== 8'd20 || bus.level !== prev_level) begin
                errors++;
                $display("[TB] FAIL square_%0d: v=%0b hp=%0d lvl=%0b expected v=1 hp=20 lvl=%0b",
                         i, bus.valid, bus.half_period, bus.level, prev_level);
            end
            wait_neg(1);
            checks++;
            if (bus.valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL square_strobe_%0d: valid=%0b expected 0", i, bus.valid);
            end
            wait_neg(16);
        end
    endtask

    // High 30 / low 10 (input is high and 20 cycles old on entry)
    task automatic test_asymmetric();
        wait_neg(10);
        for (int i = 0; i < 2; i++) begin
            flip();
            wait_neg(3);
            checks++;
            if (bus.valid !== 1'b1 || bus.half_period !== 8'd30 || bus.level !== 1'b1) begin
                errors++;
                $display("[TB] FAIL asym_high_%0d: v=%0b hp=%0d lvl=%0b expected v=1 hp=30 lvl=1",
                         i, bus.valid, bus.half_period, bus.level);
            end
            wait_neg(7);
            flip();
            wait_neg(3);
            checks++;
            if (bus.valid !== 1'b1 || bus.half_period !== 8'd10 || bus.level !== 1'b0) begin
                errors++;
                $display("[TB] FAIL asym_low_%0d: v=%0b hp=%0d lvl=%0b expected v=1 hp=10 lvl=0",
                         i, bus.valid, bus.half_period, bus.level);
            end
            wait_neg(27);
        end
    endtask

    // 3-cycle pulse is a glitch, 4-cycle pulse is the shortest valid interval
    task automatic test_glitch();
        flip();                 // ends a 30-cycle high
        wait_neg(20);
        flip();                 // 20-cycle low ends
        wait_neg(20);
        flip();                 // 20-cycle high ends
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b1 || bus.half_period !== 8'd20 || bus.level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_glitch: v=%0b hp=%0d lvl=%0b expected v=1 hp=20 lvl=1",
                     bus.valid, bus.half_period, bus.level);
        end
        flip();                 // 3-cycle low pulse ends
        wait_neg(3);
        checks++;
        if (bus.glitch !== 1'b1 || bus.valid !== 1'b0 || bus.half_period !== 8'd20 || bus.level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_3: g=%0b v=%0b hp=%0d lvl=%0b expected g=1 v=0 hp=20 lvl=1",
                     bus.glitch, bus.valid, bus.half_period, bus.level);
        end
        wait_neg(1);
        checks++;
        if (bus.glitch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_strobe: glitch=%0b expected 0", bus.glitch);
        end
        wait_neg(16);
        flip();                 // 20-cycle high measured from the glitch edge
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b1 || bus.half_period !== 8'd20 || bus.level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_glitch: v=%0b hp=%0d lvl=%0b expected v=1 hp=20 lvl=1",
                     bus.valid, bus.half_period, bus.level);
        end
        wait_neg(1);
        flip();                 // 4-cycle low pulse ends
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b1 || bus.glitch !== 1'b0 || bus.half_period !== 8'd4 || bus.level !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pulse_4: v=%0b g=%0b hp=%0d lvl=%0b expected v=1 g=0 hp=4 lvl=0",
                     bus.valid, bus.glitch, bus.half_period, bus.level);
        end
        wait_neg(17);
    endtask

    // Input held constant: stall after the timeout, recovery on the next edge
    task automatic test_stall();
        flip();                 // 1 -> 0 after 20 high
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b1 || bus.half_period !== 8'd20 || bus.level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_stall: v=%0b hp=%0d lvl=%0b expected v=1 hp=20 lvl=1",
                     bus.valid, bus.half_period, bus.level);
        end
        wait_neg(99);
        checks++;
        if (bus.stalled !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_early: stalled=%0b expected 0", bus.stalled);
        end
        wait_neg(1);
        checks++;
        if (bus.stalled !== 1'b1 || bus.valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_assert: s=%0b v=%0b expected s=1 v=0",
                     bus.stalled, bus.valid);
        end
        wait_neg(50);
        flip();                 // recovery edge
        wait_neg(2);
        checks++;
        if (bus.stalled !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_hold: stalled=%0b expected 1", bus.stalled);
        end
        wait_neg(1);
        checks++;
        if (bus.stalled !== 1'b0 || bus.valid !== 1'b0 || bus.half_period !== 8'd20) begin
            errors++;
            $display("[TB] FAIL stall_recover: s=%0b v=%0b hp=%0d expected s=0 v=0 hp=20",
                     bus.stalled, bus.valid, bus.half_period);
        end
        wait_neg(17);
        flip();
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b1 || bus.half_period !== 8'd20 || bus.level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_stall: v=%0b hp=%0d lvl=%0b expected v=1 hp=20 lvl=1",
                     bus.valid, bus.half_period, bus.level);
        end
        wait_neg(17);
    endtask

    // Edge exactly at the timeout: edge wins, no stall
    task automatic test_timeout_boundary();
        flip();                 // 0 -> 1 after 20 low
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b1 || bus.half_period !== 8'd20 || bus.level !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_boundary: v=%0b hp=%0d lvl=%0b expected v=1 hp=20 lvl=0",
                     bus.valid, bus.half_period, bus.level);
        end
        wait_neg(97);
        flip();                 // 100 cycles after the previous toggle
        wait_neg(2);
        checks++;
        if (bus.stalled !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boundary_pre_stall: stalled=%0b expected 0", bus.stalled);
        end
        wait_neg(1);
        checks++;
        if (bus.valid !== 1'b1 || bus.half_period !== 8'd100 || bus.level !== 1'b1 || bus.stalled !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boundary_100: v=%0b hp=%0d lvl=%0b s=%0b expected v=1 hp=100 lvl=1 s=0",
                     bus.valid, bus.half_period, bus.level, bus.stalled);
        end
        wait_neg(1);
        checks++;
        if (bus.stalled !== 1'b0) begin
            errors++;
            $display("[TB] FAIL boundary_post_stall: stalled=%0b expected 0", bus.stalled);
        end
        wait_neg(5);
    endtask

    // Asynchronous reset between clock edges, then restart with input high
    task automatic test_reset_midway();
        flip();                 // 0 -> 1
        wait_neg(10);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.half_period, bus.level, bus.valid, bus.glitch, bus.stalled} !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: hp=%0d lvl=%0b v=%0b g=%0b s=%0b expected all 0",
                     bus.half_period, bus.level, bus.valid, bus.glitch, bus.stalled);
        end
        wait_neg(3);
        reset_n = 1'b1;
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b0 || bus.glitch !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_edge: v=%0b g=%0b expected v=0 g=0",
                     bus.valid, bus.glitch);
        end
        wait_neg(17);
        flip();                 // 20 cycles after release
        wait_neg(3);
        checks++;
        if (bus.valid !== 1'b1 || bus.half_period !== 8'd20 || bus.level !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_reset: v=%0b hp=%0d lvl=%0b expected v=1 hp=20 lvl=1",
                     bus.valid, bus.half_period, bus.level);
        end
        wait_neg(5);
    endtask

    // Runs every scenario in order and prints the summary
    initial begin
        bus.flash_in = 1'b0;
        prev_level   = 1'b0;
        test_reset();
        test_square();
        test_asymmetric();
        test_glitch();
        test_stall();
        test_timeout_boundary();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guards against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not end, expected end before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
